tx_dcrc_gen: RTL
================

# tx_dcrc_gen

Transmit-side USB data CRC16 generator. It passes outgoing packet data bits through, one bit per bit-rate enable strobe, while running the CRC16 LFSR. After the final data bit it appends the complemented 16-bit CRC. It sits between the TX data shifter and the bit-stuffer/NRZI encoder, and uses the same bit-rate enable as the rest of the TX path.

## Interface
Parameters: none.

Ports:
- clk  in  1  system clock.
- n_rst  in  1  reset, active-low. Reset is synchronous to clk, so it takes effect only on a rising edge of clk.
- bit_enable  in  1  one-cycle strobe, once per USB bit time; gates every bit-level action.
- tx_start  in  1  begin a packet; accepted only in IDLE.
- tx_bit_in  in  1  next payload bit, LSB-first; sampled on bit_enable in DATA.
- tx_data_last  in  1  qualifies the tx_bit_in currently sampled as the final payload bit. If high together with tx_start, the packet is zero-length.
- tx_bit_out  out  1  registered serial output bit.
- tx_bit_valid  out  1  one-cycle pulse: tx_bit_out was updated this cycle.
- crc_busy  out  1  high in DATA and CRC.
- crc_done  out  1  one-cycle pulse after the last CRC bit is emitted.
- crc_value  out  16  complemented CRC of the current packet; bit 15 is transmitted first.

## Operation
- States: IDLE, DATA, CRC, DONE.
- IDLE:
  - tx_start with tx_data_last=0 → DATA, lfsr←16'hFFFF.
  - tx_start with tx_data_last=1 → CRC, lfsr←16'hFFFF, crc_value←16'h0000, count←0.
  - bit_enable alone is ignored.
- DATA, on bit_enable:
  - fb = lfsr[15]^tx_bit_in; lfsr←{lfsr[14:0],1'b0} ^ (fb ? 16'h8005 : 0).
  - tx_bit_out←tx_bit_in; tx_bit_valid←1.
  - If tx_data_last=1 → CRC, crc_value←~next_lfsr, count←0.
- CRC, on bit_enable:
  - tx_bit_out←crc_value[15-count]; tx_bit_valid←1; count←count+1.
  - At count==15 → DONE.
  - count is 4 bits and never wraps past 15.
- DONE: crc_done←1 for one cycle → IDLE. No bit_enable is required.
- Cycles without bit_enable in DATA/CRC: all state holds and tx_bit_valid=0.
- tx_start outside IDLE is ignored. tx_data_last outside DATA, or without bit_enable, is ignored.
- tx_start and bit_enable in the same IDLE cycle: start is accepted and that strobe carries no data.
- crc_value holds until the next accepted tx_start loads it.

## Timing
- Reset values: state=IDLE, lfsr=16'hFFFF, crc_value=16'h0000, count=0, tx_bit_out=1, tx_bit_valid=0, crc_busy=0, crc_done=0.
- Reset asserted mid-packet: on the next edge the block is in IDLE with reset values. No CRC bits are emitted and crc_done does not pulse.
- Latency: tx_bit_out and tx_bit_valid update on the edge that samples bit_enable, so they are visible one cycle after the strobe.
- Packet of N payload bits: N+16 tx_bit_valid pulses. crc_done follows one cycle after the 16th CRC bit.
- crc_busy rises the cycle after tx_start is accepted and falls on entry to DONE.
- Back-to-back: the next tx_start is accepted in the cycle after crc_done, once the block is back in IDLE.

## Configuration
- TX_DCRC_ABORT_EN defined:
  - Adds input port tx_abort (1 bit).
  - tx_abort=1 in any state → IDLE on the next edge, lfsr←16'hFFFF, tx_bit_valid=0, no crc_done pulse.
  - tx_abort has priority over tx_start and bit_enable.
- TX_DCRC_ABORT_EN undefined: the port is absent and packets always run to completion.

## Test plan
- Reset: drive n_rst=0 for 2 cycles with clk running → all outputs at their reset values. Holding n_rst=0 without a clock edge → no change, which confirms the reset is synchronous.
- Zero-length packet: tx_start + tx_data_last → 16 tx_bit_out=0 bits, crc_value=16'h0000, crc_done once.
- ASCII "123456789" (72 bits, LSB-first):
  - crc_value=16'h132D, which is the bit-reversal of CRC-16/USB check value 16'hB4C8.
  - First CRC bit emitted is 0.
  - Exactly 88 tx_bit_valid pulses.
- Residual check: feed a random 64-bit payload, then loop the emitted CRC bits through a reference LFSR → final register 16'h800D. Repeat with bit_enable every 4 cycles.
- Ignored inputs:
  - tx_start pulsed mid-DATA → no restart, CRC unchanged.
  - tx_data_last high without bit_enable → stays in DATA.
- With TX_DCRC_ABORT_EN: tx_abort after the 5th CRC bit → IDLE next cycle, no crc_done, next packet's CRC correct.

Source files
------------

// File: rtl/tx_dcrc_gen.sv
// USB transmit data CRC16 generator: passes payload bits through, then appends the complemented CRC16.
// Optional abort input enabled by defining TX_DCRC_ABORT_EN.
module tx_dcrc_gen (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        bit_enable,
  input  logic        tx_start,
  input  logic        tx_bit_in,
  input  logic        tx_data_last,
`ifdef TX_DCRC_ABORT_EN
  input  logic        tx_abort,
`endif
  output logic        tx_bit_out,
  output logic        tx_bit_valid,
  output logic        crc_busy,
  output logic        crc_done,
  output logic [15:0] crc_value
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DATA = 2'd1;
  localparam logic [1:0] ST_CRC  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // One serial step of the CRC16 LFSR, polynomial x^16 + x^15 + x^2 + 1.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
    logic fb;
    fb = crc[15] ^ din;
    return {crc[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
  endfunction

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [15:0] lfsr;
  logic [15:0] lfsr_nxt;
  logic [15:0] lfsr_step;
  logic [15:0] crc_nxt;
  logic [3:0]  count;
  logic [3:0]  count_nxt;
  logic        bit_nxt;
  logic        valid_nxt;
  logic        done_nxt;
  logic        busy_nxt;
  logic        abort;

`ifdef TX_DCRC_ABORT_EN
  assign abort = tx_abort;
`else
  assign abort = 1'b0;
`endif

  // Next-state and datapath decode for all four states.
  always_comb begin
    state_nxt = state;
    lfsr_nxt  = lfsr;
    crc_nxt   = crc_value;
    count_nxt = count;
    bit_nxt   = tx_bit_out;
    valid_nxt = 1'b0;
    done_nxt  = 1'b0;
    lfsr_step = crc16_step(lfsr, tx_bit_in);
    if (abort) begin
      state_nxt = ST_IDLE;
      lfsr_nxt  = 16'hFFFF;
    end else begin
      case (state)
        ST_IDLE: begin
          if (tx_start) begin
            lfsr_nxt = 16'hFFFF;
            if (tx_data_last) begin
              state_nxt = ST_CRC;
              crc_nxt   = 16'h0000;
              count_nxt = 4'd0;
            end else begin
              state_nxt = ST_DATA;
            end
          end else begin
            state_nxt = ST_IDLE;
          end
        end
        ST_DATA: begin
          if (bit_enable) begin
            lfsr_nxt  = lfsr_step;
            bit_nxt   = tx_bit_in;
            valid_nxt = 1'b1;
            if (tx_data_last) begin
              state_nxt = ST_CRC;
              crc_nxt   = ~lfsr_step;
              count_nxt = 4'd0;
            end else begin
              state_nxt = ST_DATA;
            end
          end else begin
            state_nxt = ST_DATA;
          end
        end
        ST_CRC: begin
          if (bit_enable) begin
            bit_nxt   = crc_value[4'd15 - count];
            valid_nxt = 1'b1;
            // count saturates at 15; the DONE transition ends the CRC field
            if (count == 4'd15) begin
              state_nxt = ST_DONE;
            end else begin
              count_nxt = count + 4'd1;
            end
          end else begin
            state_nxt = ST_CRC;
          end
        end
        ST_DONE: begin
          done_nxt  = 1'b1;
          state_nxt = ST_IDLE;
        end
        default: begin
          state_nxt = ST_IDLE;
          lfsr_nxt  = 16'hFFFF;
        end
      endcase
    end
    busy_nxt = (state_nxt == ST_DATA) || (state_nxt == ST_CRC);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state        <= ST_IDLE;
      lfsr         <= 16'hFFFF;
      crc_value    <= 16'h0000;
      count        <= 4'd0;
      tx_bit_out   <= 1'b1;
      tx_bit_valid <= 1'b0;
      crc_busy     <= 1'b0;
      crc_done     <= 1'b0;
    end else begin
      state        <= state_nxt;
      lfsr         <= lfsr_nxt;
      crc_value    <= crc_nxt;
      count        <= count_nxt;
      tx_bit_out   <= bit_nxt;
      tx_bit_valid <= valid_nxt;
      crc_busy     <= busy_nxt;
      crc_done     <= done_nxt;
    end
  end

endmodule
